mem_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single-ported unified instruction/data memory of the multicycle core.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arb_rr_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and owner encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way requester pick: fixed priority (mode=0) or round-robin (mode=1).
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ld_req,
    input  logic last_owner,
    input  logic mode,
    output logic owner,
    output logic valid
);

    always_comb begin
        valid = cpu_req | ld_req;
        owner = OWN_CPU;
        if (cpu_req && ld_req) begin
            // On a tie in round-robin mode, the requester that did not go last wins.
            owner = mode ? ~last_owner : OWN_CPU;
        end else if (ld_req) begin
            owner = OWN_LD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/loader arbiter and sequencer for the single-ported unified memory.
// Define MEM_ARB_ROM_WP_EN to reject writes into the ROM region.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ROM_WORDS = 16,
    parameter int unsigned ARB_MODE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              err
);

`ifdef MEM_ARB_ROM_WP_EN
    localparam bit ROM_WP = 1'b1;
`else
    localparam bit ROM_WP = 1'b0;
`endif

    state_t            state, state_next;
    logic              owner, last_owner;
    logic              pick_owner, pick_valid;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              out_of_range, reject;
    logic [DATA_W-1:0] rd_value;

    mem_arb_rr_pick u_pick (
        .cpu_req    (cpu_req),
        .ld_req     (ld_req),
        .last_owner (last_owner),
        .mode       (ARB_MODE != 0),
        .owner      (pick_owner),
        .valid      (pick_valid)
    );

    assign out_of_range   = lat_addr >= ADDR_W'(DEPTH);
    assign reject         = out_of_range | (ROM_WP & lat_we & (lat_addr < ADDR_W'(ROM_WORDS)));
    assign rd_value       = out_of_range ? '0 : mem_data_in;
    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next   = state;
        cpu_gnt      = 1'b0;
        ld_gnt       = 1'b0;
        cpu_done     = 1'b0;
        ld_done      = 1'b0;
        err          = 1'b0;
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) state_next = ACCESS;
            end
            ACCESS: begin
                cpu_gnt      = (owner == OWN_CPU);
                ld_gnt       = (owner == OWN_LD);
                mem_MemRead  = ~lat_we & ~out_of_range;
                mem_MemWrite = lat_we & ~reject;
                state_next   = RESP;
            end
            RESP: begin
                cpu_done   = (owner == OWN_CPU);
                ld_done    = (owner == OWN_LD);
                err        = reject;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_CPU;
            last_owner <= OWN_LD;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                owner     <= pick_owner;
                lat_we    <= (pick_owner == OWN_CPU) ? cpu_we    : ld_we;
                lat_addr  <= (pick_owner == OWN_CPU) ? cpu_addr  : ld_addr;
                lat_wdata <= (pick_owner == OWN_CPU) ? cpu_wdata : ld_wdata;
            end
            if (state == ACCESS) begin
                last_owner <= owner;
                if (!lat_we) begin
                    if (owner == OWN_CPU) cpu_rdata <= rd_value;
                    else                  ld_rdata  <= rd_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a word-level reference model of memory and read-back registers.
// Expectations follow MEM_ARB_ROM_WP_EN when it is defined for the build.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROM_WP_EN
    localparam bit ROM_WP = 1'b1;
`else
    localparam bit ROM_WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_gnt, cpu_done, ld_gnt, ld_done, err;
    logic [31:0] cpu_rdata, ld_rdata;
    logic [31:0] mem_address, mem_write_data, mem_data_in;
    logic        mem_MemRead, mem_MemWrite;

    logic        fp_cpu_gnt, fp_cpu_done, fp_ld_gnt, fp_ld_done, fp_err;
    logic [31:0] fp_cpu_rdata, fp_ld_rdata, fp_mem_address, fp_mem_write_data;
    logic        fp_MemRead, fp_MemWrite;
    logic [31:0] fp_mem_data_in;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [31:0] exp_cpu_rd, exp_ld_rd;
    bit          load_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .ROM_WORDS(16), .ARB_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .mem_address(mem_address), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_write_data(mem_write_data), .mem_data_in(mem_data_in), .err(err)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .ROM_WORDS(16), .ARB_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(fp_cpu_gnt), .cpu_done(fp_cpu_done), .cpu_rdata(fp_cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(fp_ld_gnt), .ld_done(fp_ld_done), .ld_rdata(fp_ld_rdata),
        .mem_address(fp_mem_address), .mem_MemRead(fp_MemRead), .mem_MemWrite(fp_MemWrite),
        .mem_write_data(fp_mem_write_data), .mem_data_in(fp_mem_data_in), .err(fp_err)
    );

    function automatic logic [31:0] init_word(int unsigned i);
        return (i == 17) ? 32'd11 : ((32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000);
    endfunction

    // Memory behaviour: combinational read, write committed at posedge.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int unsigned i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (mem_MemWrite && mem_address < 32) begin
            mem[mem_address[4:0]] <= mem_write_data;
        end
    end
    assign mem_data_in    = (mem_address < 32) ? mem[mem_address[4:0]] : 32'hBAD0_0BAD;
    assign fp_mem_data_in = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit who, input logic val, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (who) begin
            ld_req = val; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end else begin
            cpu_req = val; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // One isolated transaction; entered and left just after a posedge with the arbiter idle.
    task automatic txn(input bit who, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit          in_range, rej;
        logic        g;
        int unsigned cyc;
        in_range = (addr < 32);
        rej      = !in_range || (ROM_WP && we && addr < 16);
        drive_req(who, 1'b1, we, addr, wdata);
        cyc = 0;
        g   = 1'b0;
        while (!g && cyc < 8) begin
            @(negedge clk);
            cyc++;
            g = who ? ld_gnt : cpu_gnt;
            if (!g) begin @(posedge clk); #1; end
        end
        chk("gnt_latency", 32'(cyc), 32'd2);
        chk("other_gnt", 32'(who ? cpu_gnt : ld_gnt), 32'd0);
        chk("mem_read_en", 32'(mem_MemRead), 32'(in_range && !we));
        chk("mem_write_en", 32'(mem_MemWrite), 32'(we && !rej));
        if (in_range) chk("mem_address", mem_address, addr);
        if (we && !rej) chk("mem_write_data", mem_write_data, wdata);
        @(posedge clk); #1;
        drive_req(who, 1'b0, 1'b0, '0, '0);
        if (!we) begin
            if (who) exp_ld_rd  = in_range ? ref_mem[addr[4:0]] : 32'd0;
            else     exp_cpu_rd = in_range ? ref_mem[addr[4:0]] : 32'd0;
        end else if (!rej) begin
            ref_mem[addr[4:0]] = wdata;
        end
        @(negedge clk);
        chk("own_done", 32'(who ? ld_done : cpu_done), 32'd1);
        chk("other_done", 32'(who ? cpu_done : ld_done), 32'd0);
        chk("err", 32'(err), 32'(rej));
        chk("resp_enables", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
        chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
        chk("ld_rdata", ld_rdata, exp_ld_rd);
        if (in_range) chk("mem_content", mem[addr[4:0]], ref_mem[addr[4:0]]);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cpu_rd = '0;
        exp_ld_rd  = '0;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic        grant_who [$];
        int unsigned grant_cyc [$];
        int unsigned fp_cpu_cnt, fp_ld_cnt, both_cnt, cyc;

        rst = 1'b0; load_mem = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        exp_cpu_rd = '0; exp_ld_rd = '0;
        for (int unsigned i = 0; i < 32; i++) ref_mem[i] = init_word(i);

        #2;
        chk("rst_gnt", 32'({cpu_gnt, ld_gnt}), 32'd0);
        chk("rst_done_err", 32'({cpu_done, ld_done, err}), 32'd0);
        chk("rst_enables", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'd0);
        @(posedge clk); #1;
        load_mem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed: basic read, loader write then CPU read-back, ROM write, out-of-range read.
        txn(1'b0, 1'b0, 32'd17, '0);
        txn(1'b1, 1'b1, 32'd20, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'd20, '0);
        txn(1'b0, 1'b1, 32'd3, 32'hCAFE_0003);
        txn(1'b0, 1'b0, 32'd3, '0);
        txn(1'b1, 1'b0, 32'd40, '0);
        txn(1'b1, 1'b1, 32'd32, 32'h1111_2222);
        txn(1'b1, 1'b0, 32'd31, '0);

        // Both requesters held: round-robin alternates, fixed priority always serves the CPU.
        pulse_reset();
        drive_req(1'b0, 1'b1, 1'b0, 32'd18, '0);
        drive_req(1'b1, 1'b1, 1'b0, 32'd19, '0);
        fp_cpu_cnt = 0; fp_ld_cnt = 0; both_cnt = 0; cyc = 0;
        while (grant_who.size() < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_gnt && ld_gnt) both_cnt++;
            if (cpu_gnt) begin grant_who.push_back(1'b0); grant_cyc.push_back(cyc); end
            else if (ld_gnt) begin grant_who.push_back(1'b1); grant_cyc.push_back(cyc); end
            if (fp_cpu_gnt) fp_cpu_cnt++;
            if (fp_ld_gnt)  fp_ld_cnt++;
        end
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rr_grant_count", 32'(grant_who.size()), 32'd6);
        chk("rr_both_granted", 32'(both_cnt), 32'd0);
        for (int unsigned i = 0; i < grant_who.size(); i++) begin
            chk("rr_order", 32'(grant_who[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 32'd3);
        end
        chk("fp_cpu_grants", 32'(fp_cpu_cnt), 32'd6);
        chk("fp_ld_grants", 32'(fp_ld_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_cpu_rd = ref_mem[18];
        exp_ld_rd  = ref_mem[19];
        chk("rr_cpu_rdata", cpu_rdata, exp_cpu_rd);
        chk("rr_ld_rdata", ld_rdata, exp_ld_rd);

        // Randomized isolated transactions across ROM, RAM and out-of-range addresses.
        for (int unsigned n = 0; n < 40; n++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 47)), $urandom);
        end

        // Reset while a write is on the memory: the write must be lost and no completion emitted.
        drive_req(1'b1, 1'b1, 1'b1, 32'd25, 32'h1234_5678);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_gnt_before", 32'(ld_gnt), 32'd1);
        chk("abort_write_en_before", 32'(mem_MemWrite), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_gnt", 32'(ld_gnt), 32'd0);
        chk("abort_write_en", 32'(mem_MemWrite), 32'd0);
        chk("abort_mem_address", mem_address, 32'd0);
        chk("abort_mem_write_data", mem_write_data, 32'd0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        exp_cpu_rd = '0;
        exp_ld_rd  = '0;
        @(negedge clk);
        chk("abort_no_done", 32'({cpu_done, ld_done, err}), 32'd0);
        chk("abort_write_lost", mem[25], ref_mem[25]);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_idle_quiet", 32'({cpu_gnt, ld_gnt, cpu_done, ld_done}), 32'd0);
        end
        chk("abort_ld_rdata", ld_rdata, 32'd0);
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 32'd25, '0);
        txn(1'b0, 1'b0, 32'd17, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
